// File: rtl/stopwatch_timer_if.sv
// Control pulses, BCD display digits and status flags shared between the
// stopwatch core (slave) and whatever drives it (master).
interface stopwatch_timer_if;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic        mode;
    logic        load;
    logic [23:0] preset;

    logic [3:0]  cs0;
    logic [3:0]  cs1;
    logic [3:0]  sec0;
    logic [3:0]  sec1;
    logic [3:0]  min0;
    logic [3:0]  min1;
    logic [3:0]  hrs0;
    logic [3:0]  hrs1;
    logic        running;
    logic        lap_active;
    logic        done;
    logic        load_err;
    logic        tick;

    modport master (
        output start_stop, clear, lap, mode, load, preset,
        input  cs0, cs1, sec0, sec1, min0, min1, hrs0, hrs1,
        input  running, lap_active, done, load_err, tick
    );

    modport slave (
        input  start_stop, clear, lap, mode, load, preset,
        output cs0, cs1, sec0, sec1, min0, min1, hrs0, hrs1,
        output running, lap_active, done, load_err, tick
    );
endinterface

// File: rtl/stopwatch_timer.sv
// BCD stopwatch / countdown timer (hh:mm:ss.cc) advancing on an internal
// clock-enable tick, with lap freeze, validated preset load and hour wrap.
module stopwatch_timer #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned HOURS_WRAP = 24
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_timer_if.slave bus
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [3:0]    HRS_MAX1 = 4'((HOURS_WRAP - 1) / 10);
    localparam logic [3:0]    HRS_MAX0 = 4'((HOURS_WRAP - 1) % 10);

    typedef struct packed {
        logic [3:0] hrs1;
        logic [3:0] hrs0;
        logic [3:0] min1;
        logic [3:0] min0;
        logic [3:0] sec1;
        logic [3:0] sec0;
        logic [3:0] cs1;
        logic [3:0] cs0;
    } bcd_t;

    typedef enum logic {ST_STOP, ST_RUN} state_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    state_e      state_q, state_d;
    dir_e        dir_q, dir_d;
    bcd_t        cnt_q, cnt_d;
    bcd_t        latch_q, latch_d;
    bcd_t        disp_q, disp_d;
    logic [PW-1:0] pre_q, pre_d;
    logic        lap_act_q, lap_act_d;
    logic        done_q, done_d;
    logic        load_err_q, load_err_d;
    logic        tick_q, tick_d;
    logic        tick_now;
    logic        preset_ok;
    logic [7:0]  hrs_val;

    // Returns {next_digit, carry_out}.
    function automatic logic [4:0] digit_up(input logic [3:0] d, input logic [3:0] lim,
                                            input logic cin);
        if (!cin)          return {d, 1'b0};
        else if (d == lim) return {4'd0, 1'b1};
        else               return {d + 4'd1, 1'b0};
    endfunction

    // Returns {next_digit, borrow_out}.
    function automatic logic [4:0] digit_dn(input logic [3:0] d, input logic [3:0] lim,
                                            input logic bin);
        if (!bin)          return {d, 1'b0};
        else if (d == '0)  return {lim, 1'b1};
        else               return {d - 4'd1, 1'b0};
    endfunction

    function automatic bcd_t count_up(input bcd_t t);
        bcd_t r;
        logic cy;
        r = t;
        {r.cs0, cy}  = digit_up(t.cs0,  4'd9, 1'b1);
        {r.cs1, cy}  = digit_up(t.cs1,  4'd9, cy);
        {r.sec0, cy} = digit_up(t.sec0, 4'd9, cy);
        {r.sec1, cy} = digit_up(t.sec1, 4'd5, cy);
        {r.min0, cy} = digit_up(t.min0, 4'd9, cy);
        {r.min1, cy} = digit_up(t.min1, 4'd5, cy);
        if (cy) begin
            if (t.hrs1 == HRS_MAX1 && t.hrs0 == HRS_MAX0) begin
                r.hrs1 = '0;
                r.hrs0 = '0;
            end else if (t.hrs0 == 4'd9) begin
                r.hrs0 = '0;
                r.hrs1 = t.hrs1 + 4'd1;
            end else begin
                r.hrs0 = t.hrs0 + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic bcd_t count_dn(input bcd_t t);
        bcd_t r;
        logic bw;
        r = t;
        {r.cs0, bw}  = digit_dn(t.cs0,  4'd9, 1'b1);
        {r.cs1, bw}  = digit_dn(t.cs1,  4'd9, bw);
        {r.sec0, bw} = digit_dn(t.sec0, 4'd9, bw);
        {r.sec1, bw} = digit_dn(t.sec1, 4'd5, bw);
        {r.min0, bw} = digit_dn(t.min0, 4'd9, bw);
        {r.min1, bw} = digit_dn(t.min1, 4'd5, bw);
        if (bw) begin
            if (t.hrs1 == '0 && t.hrs0 == '0) begin
                r.hrs1 = HRS_MAX1;
                r.hrs0 = HRS_MAX0;
            end else if (t.hrs0 == '0) begin
                r.hrs0 = 4'd9;
                r.hrs1 = t.hrs1 - 4'd1;
            end else begin
                r.hrs0 = t.hrs0 - 4'd1;
            end
        end
        return r;
    endfunction

    always_comb begin
        hrs_val   = 8'(bus.preset[23:20]) * 8'd10 + 8'(bus.preset[19:16]);
        preset_ok = (bus.preset[23:20] <= 4'd9) && (bus.preset[19:16] <= 4'd9) &&
                    (bus.preset[15:12] <= 4'd5) && (bus.preset[11:8]  <= 4'd9) &&
                    (bus.preset[7:4]   <= 4'd5) && (bus.preset[3:0]   <= 4'd9) &&
                    (hrs_val < 8'(HOURS_WRAP));
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        latch_d    = latch_q;
        pre_d      = pre_q;
        lap_act_d  = lap_act_q;
        done_d     = done_q;
        load_err_d = 1'b0;
        tick_d     = 1'b0;
        tick_now   = (state_q == ST_RUN) && (pre_q == PRE_MAX);

        // The tick is applied first; control pulses then override or stop it.
        if (state_q == ST_RUN) begin
            if (tick_now) begin
                pre_d  = '0;
                tick_d = 1'b1;
                cnt_d  = (dir_q == DIR_DOWN) ? count_dn(cnt_q) : count_up(cnt_q);
                if (dir_q == DIR_DOWN && cnt_d == '0) begin
                    state_d = ST_STOP;
                    done_d  = 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        if (bus.clear) begin
            cnt_d     = '0;
            latch_d   = '0;
            pre_d     = '0;
            state_d   = ST_STOP;
            lap_act_d = 1'b0;
            done_d    = 1'b0;
        end else if (bus.load) begin
            if (state_q == ST_STOP) begin
                if (preset_ok) begin
                    cnt_d  = bcd_t'({bus.preset, 8'h00});
                    pre_d  = '0;
                    done_d = 1'b0;
                end else begin
                    load_err_d = 1'b1;
                end
            end
        end else if (bus.start_stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_STOP;
            end else begin
                dir_d = bus.mode ? DIR_DOWN : DIR_UP;
                if (bus.mode && cnt_q == '0) done_d = 1'b1;
                else                         state_d = ST_RUN;
            end
        end else if (bus.lap) begin
            // Latch takes the pre-tick value when a tick lands in the same cycle.
            if (state_q == ST_RUN && !lap_act_q) begin
                latch_d   = cnt_q;
                lap_act_d = 1'b1;
            end else if (lap_act_q) begin
                lap_act_d = 1'b0;
            end
        end

        disp_d = lap_act_d ? latch_d : cnt_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_STOP;
            dir_q      <= DIR_UP;
            cnt_q      <= '0;
            latch_q    <= '0;
            disp_q     <= '0;
            pre_q      <= '0;
            lap_act_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            latch_q    <= latch_d;
            disp_q     <= disp_d;
            pre_q      <= pre_d;
            lap_act_q  <= lap_act_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.hrs1       = disp_q.hrs1;
    assign bus.hrs0       = disp_q.hrs0;
    assign bus.min1       = disp_q.min1;
    assign bus.min0       = disp_q.min0;
    assign bus.sec1       = disp_q.sec1;
    assign bus.sec0       = disp_q.sec0;
    assign bus.cs1        = disp_q.cs1;
    assign bus.cs0        = disp_q.cs0;
    assign bus.running    = (state_q == ST_RUN);
    assign bus.lap_active = lap_act_q;
    assign bus.done       = done_q;
    assign bus.load_err   = load_err_q;
    assign bus.tick       = tick_q;
endmodule
